// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID decoupling FIFO. Each entry carries the fetch PC, the
// instruction word, the fetch-TLB exception set and the virtual fetch address.
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN. When it is defined, an empty
// queue forwards a pushed entry straight to id_* in the same cycle.
// Exception set layout (8 bits): bit0 = inst_tlb_refill, bit1 = inst_tlb_invalid,
// all other bits are reserved and driven 0.

`ifndef PC_RESET_ADDR
  `define PC_RESET_ADDR 32'hbfc0_0000
`endif
`ifndef ZERO_WORD
  `define ZERO_WORD 32'h0000_0000
`endif
`ifndef NO_EXCP
  `define NO_EXCP 8'h00
`endif

module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_push,
  output logic             if_ready,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             if_miss,
  input  logic             if_valid,
  input  logic [31:0]      if_inst_addr_v,
  output logic             id_valid,
  input  logic             id_pop,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic [7:0]       id_exception_type,
  output logic [31:0]      id_inst_addr_v,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam int EXC_TLB_REFILL  = 0;
  localparam int EXC_TLB_INVALID = 1;

  function automatic logic [7:0] map_exc(input logic miss, input logic tlb_valid);
    logic [7:0] e;
    e                  = '0;
    e[EXC_TLB_REFILL]  = miss;
    e[EXC_TLB_INVALID] = ~tlb_valid;
    return e;
  endfunction

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [7:0]       exc_mem  [DEPTH];
  logic [31:0]      addr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             not_empty;
  logic             wr_en;
  logic             rd_en;

  assign not_empty = (count_q != '0);
  assign if_ready  = (count_q != FULL_CNT);
  assign count     = count_q;
  assign rd_en     = id_pop & not_empty & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic bypass_take;
  assign bypass_take = ~not_empty & if_push & ~flush;
  // A bypassed entry that ID consumes in the same cycle never lands in storage.
  assign wr_en       = if_push & if_ready & ~flush & ~(bypass_take & id_pop);
  assign id_valid    = not_empty | bypass_take;
`else
  assign wr_en       = if_push & if_ready & ~flush;
  assign id_valid    = not_empty;
`endif

  // Entry storage: written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
      exc_mem[wr_ptr]  <= map_exc(if_miss, if_valid);
      addr_mem[wr_ptr] <= if_inst_addr_v;
    end
  end

  // Pointer and occupancy bookkeeping; flush clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation: stored head, optional bypass, otherwise bubble values.
  always_comb begin
    id_pc             = `PC_RESET_ADDR;
    id_inst           = `ZERO_WORD;
    id_exception_type = `NO_EXCP;
    id_inst_addr_v    = `ZERO_WORD;
    if (not_empty) begin
      id_pc             = pc_mem[rd_ptr];
      id_inst           = inst_mem[rd_ptr];
      id_exception_type = exc_mem[rd_ptr];
      id_inst_addr_v    = addr_mem[rd_ptr];
    end
`ifdef IF_ID_QUEUE_BYPASS_EN
    else if (bypass_take) begin
      id_pc             = if_pc;
      id_inst           = if_inst;
      id_exception_type = map_exc(if_miss, if_valid);
      id_inst_addr_v    = if_inst_addr_v;
    end
`endif
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    wr_en |-> (count_q != FULL_CNT));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    rd_en |-> (count_q != '0));
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the IF->ID FIFO.

module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_RST = 32'hbfc0_0000;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             if_push;
  logic             if_ready;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_miss;
  logic             if_valid;
  logic [31:0]      if_inst_addr_v;
  logic             id_valid;
  logic             id_pop;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic [7:0]       id_exception_type;
  logic [31:0]      id_inst_addr_v;
  logic [CNT_W-1:0] count;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_push(if_push), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_miss(if_miss), .if_valid(if_valid),
    .if_inst_addr_v(if_inst_addr_v), .id_valid(id_valid), .id_pop(id_pop),
    .id_pc(id_pc), .id_inst(id_inst), .id_exception_type(id_exception_type),
    .id_inst_addr_v(id_inst_addr_v), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  exc;
    logic [31:0] addr;
  } ent_t;

  typedef logic [1+1+CNT_W+32+32+8+32-1:0] snap_t;

  ent_t q[$];

  // refill flag = TLB miss, invalid flag = TLB entry not valid
  function automatic logic [7:0] exc_of(input logic miss, input logic v);
    return {6'b0, ~v, miss};
  endfunction

  function automatic snap_t observed();
    return {id_valid, if_ready, count, id_pc, id_inst, id_exception_type, id_inst_addr_v};
  endfunction

  function automatic snap_t expected();
    ent_t h;
    logic v;
    h = '{pc: PC_RST, inst: 32'h0, exc: 8'h0, addr: 32'h0};
    v = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      v = 1'b1;
    end else if (BYP && if_push && !flush) begin
      h = '{pc: if_pc, inst: if_inst, exc: exc_of(if_miss, if_valid), addr: if_inst_addr_v};
      v = 1'b1;
    end
    return {v, q.size() != DEPTH, CNT_W'(q.size()), h.pc, h.inst, h.exc, h.addr};
  endfunction

  task automatic drive(input logic p, input logic pop, input logic fl,
                       input logic [31:0] pc, input logic miss, input logic v);
    if_push        = p;
    id_pop         = pop;
    flush          = fl;
    if_pc          = pc;
    if_inst        = $urandom;
    if_miss        = miss;
    if_valid       = v;
    if_inst_addr_v = $urandom;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // Advance one clock: model updates on the edge from the inputs seen there.
  task automatic tick();
    logic do_push, do_pop;
    @(posedge clk);
    if (!rst) begin
      if (flush) begin
        q.delete();
      end else begin
        do_push = if_push && (q.size() != DEPTH);
        do_pop  = id_pop && (q.size() > 0 || (BYP && if_push));
        if (do_push)
          q.push_back('{pc: if_pc, inst: if_inst, exc: exc_of(if_miss, if_valid),
                        addr: if_inst_addr_v});
        if (do_pop) void'(q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({id_valid, if_ready, count, id_pc} !== {1'b0, 1'b1, CNT_W'(0), PC_RST}) begin
      errors++;
      $display("FAIL reset_init: got v=%0b rdy=%0b cnt=%0d pc=%h required v=0 rdy=1 cnt=0 pc=%h",
               id_valid, if_ready, count, id_pc, PC_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0200 + 32'(4 * i), 1'b0, 1'b1);
      tick();
    end
    idle();
    #1;
    checks++;
    if (count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL reset_precount: got %0d required 3", count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({id_valid, if_ready, count, id_pc} !== {1'b0, 1'b1, CNT_W'(0), PC_RST}) begin
      errors++;
      $display("FAIL reset_async: got v=%0b rdy=%0b cnt=%0d pc=%h required v=0 rdy=1 cnt=0 pc=%h",
               id_valid, if_ready, count, id_pc, PC_RST);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_order();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if ({id_valid, id_pc, count} !== {1'b1, 32'h8000_0000 + 32'(4 * i), CNT_W'(3 - i)}) begin
        errors++;
        $display("FAIL order_%0d: got v=%0b pc=%h cnt=%0d required v=1 pc=%h cnt=%0d", i,
                 id_valid, id_pc, count, 32'h8000_0000 + 32'(4 * i), 3 - i);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if ({id_valid, count} !== {1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL order_empty: got v=%0b cnt=%0d required v=0 cnt=0", id_valid, count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0100 + 32'(4 * i), 1'b0, 1'b1);
      #1;
      if (i == 4) begin
        checks++;
        if (if_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: got %0b required 0", if_ready);
        end
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if ({count, if_ready, id_pc} !== {CNT_W'(4), 1'b0, 32'h8000_0100}) begin
      errors++;
      $display("FAIL full_hold: got cnt=%0d rdy=%0b pc=%h required cnt=4 rdy=0 pc=80000100",
               count, if_ready, id_pc);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h8000_01f0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checks++;
    if ({count, id_pc} !== {CNT_W'(3), 32'h8000_0104}) begin
      errors++;
      $display("FAIL full_pushpop: got cnt=%0d pc=%h required cnt=3 pc=80000104", count, id_pc);
    end
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL full_model: got %h required %h", observed(), expected());
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_exceptions();
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0300, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({id_valid, id_exception_type} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL exc_both: got v=%0b exc=%h required v=1 exc=03", id_valid, id_exception_type);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0304, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({id_valid, id_exception_type} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL exc_none: got v=%0b exc=%h required v=1 exc=00", id_valid, id_exception_type);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0400 + 32'(4 * i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 32'h8000_04f0, 1'b0, 1'b1);
    #1;
    checks++;
    if (count !== CNT_W'(2)) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d required 2", count);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({count, id_valid, id_inst, id_pc} !== {CNT_W'(0), 1'b0, 32'h0, PC_RST}) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d v=%0b inst=%h pc=%h required cnt=0 v=0 inst=0 pc=%h",
               count, id_valid, id_inst, id_pc, PC_RST);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0500, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checks++;
    if ({id_valid, id_pc, count} !== {1'b1, 32'h8000_0500, CNT_W'(1)}) begin
      errors++;
      $display("FAIL flush_refill: got v=%0b pc=%h cnt=%0d required v=1 pc=80000500 cnt=1",
               id_valid, id_pc, count);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 1'b1);
    #1;
    checks++;
    if (BYP) begin
      if ({id_valid, id_pc} !== {1'b1, 32'h8000_0010}) begin
        errors++;
        $display("FAIL bypass_same: got v=%0b pc=%h required v=1 pc=80000010", id_valid, id_pc);
      end
    end else if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_off_same: got v=%0b required 0", id_valid);
    end
    tick();
    idle();
    #1;
    checks++;
    if (BYP) begin
      if ({id_valid, count} !== {1'b0, CNT_W'(0)}) begin
        errors++;
        $display("FAIL bypass_consumed: got v=%0b cnt=%0d required v=0 cnt=0", id_valid, count);
      end
    end else if ({id_valid, id_pc, count} !== {1'b1, 32'h8000_0010, CNT_W'(1)}) begin
      errors++;
      $display("FAIL bypass_off_next: got v=%0b pc=%h cnt=%0d required v=1 pc=80000010 cnt=1",
               id_valid, id_pc, count);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) < 6, ($urandom % 2) == 1, ($urandom % 20) == 0,
            32'h8000_0000 + ($urandom & 32'h0000_fffc), $urandom % 2 == 1, $urandom % 2 == 1);
      #1;
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_%0d: got %h required %h", i, observed(), expected());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_order();
    test_full();
    test_exceptions();
    test_flush();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
